// File: rtl/pitch_ol_scale_pkg.sv
// Shared definitions for the open-loop pitch front end: FSM states, scaling modes, defaults.
// Also holds the scale-mode decision so later stages can reuse the same rule.
package pitch_ol_scale_pkg;

    localparam int          PIT_MAX     = 143;
    localparam logic [31:0] ENER_THRESH = 32'h0010_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_E_RD   = 3'd1,
        S_E_ACC  = 3'd2,
        S_DECIDE = 3'd3,
        S_W_RD   = 3'd4,
        S_W_WR   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MODE_COPY = 2'd0,
        MODE_SHL3 = 2'd1,
        MODE_SHR3 = 2'd2
    } scale_mode_t;

    // Overflow forces down-scaling; otherwise low energy is boosted, and equality keeps a plain copy.
    function automatic scale_mode_t select_mode(input logic ovf,
                                                input logic [31:0] ener,
                                                input logic [31:0] thresh);
        scale_mode_t m;
        if (ovf)
            m = MODE_SHR3;
        else if ($signed(ener) < $signed(thresh))
            m = MODE_SHL3;
        else
            m = MODE_COPY;
        return m;
    endfunction

endpackage

// File: rtl/pitch_ol_scale_shift3.sv
// Combinational 16-bit scaler: pass-through, shift-left-3 with saturation, or arithmetic shift-right-3.
module pitch_ol_shift3
    import pitch_ol_scale_pkg::*;
(
    input  scale_mode_t mode,
    input  logic [15:0] din,
    output logic [15:0] dout
);

    logic fits;

    // A left shift by 3 is lossless only when the top four bits are all sign copies.
    assign fits = (din[15:12] == {4{din[15]}});

    always_comb begin
        dout = din;
        case (mode)
            MODE_SHL3: begin
                if (fits)
                    dout = {din[12:0], 3'b000};
                else
                    dout = din[15] ? 16'h8000 : 16'h7FFF;
            end
            MODE_SHR3: dout = {{3{din[15]}}, din[15:3]};
            default:   dout = din;
        endcase
    end

endmodule

// File: rtl/pitch_ol_scale.sv
// Energy pass then scaled-copy pass over signal[-PIT_MAX .. L_frame-1]; done pulses in cycle 4N+2.
// Define PITCH_OL_SCALE_ENERGY_EN to expose the final energy on an extra output port.
module pitch_ol_scale
    import pitch_ol_scale_pkg::*;
#(
    parameter int          PIT_MAX     = pitch_ol_scale_pkg::PIT_MAX,
    parameter int          ADDR_W      = 12,
    parameter logic [31:0] ENER_THRESH = pitch_ol_scale_pkg::ENER_THRESH
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    input  logic [ADDR_W-1:0] signal,
    input  logic [ADDR_W-1:0] scal_sig,
    input  logic [15:0]       L_frame,
    output logic [ADDR_W-1:0] readAddr,
    input  logic [31:0]       readIn,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [31:0]       writeOut,
    output logic              writeEn,
    output logic [15:0]       L_mac_a,
    output logic [15:0]       L_mac_b,
    output logic [31:0]       L_mac_c,
    input  logic [31:0]       L_mac_in,
    input  logic              L_mac_overflow,
    output logic [1:0]        scale_mode
`ifdef PITCH_OL_SCALE_ENERGY_EN
    ,
    output logic [31:0]       energy
`endif
);

    state_t            state;
    scale_mode_t       mode;
    logic [ADDR_W-1:0] k;
    logic [31:0]       t0;
    logic              ovf;

    logic [ADDR_W-1:0] sig_base;
    logic [ADDR_W-1:0] scal_base;
    logic [31:0]       n_last;
    logic              last;
    logic [15:0]       sample;
    logic [15:0]       scaled;
    logic              unused_hi;

    // Both buffers start PIT_MAX samples before their nominal origin; addresses wrap naturally.
    assign sig_base  = signal - ADDR_W'(PIT_MAX);
    assign scal_base = scal_sig - ADDR_W'(PIT_MAX);
    assign n_last    = 32'(PIT_MAX) + 32'(L_frame) - 32'd1;
    assign last      = (32'(k) == n_last);
    assign sample    = readIn[15:0];
    assign unused_hi = ^readIn[31:16];

    pitch_ol_shift3 u_shift3 (
        .mode (mode),
        .din  (sample),
        .dout (scaled)
    );

    always_comb begin
        readAddr  = '0;
        writeAddr = '0;
        writeOut  = '0;
        writeEn   = 1'b0;
        L_mac_a   = '0;
        L_mac_b   = '0;
        L_mac_c   = '0;
        case (state)
            S_E_RD, S_W_RD: readAddr = sig_base + k;
            S_E_ACC: begin
                L_mac_a = sample;
                L_mac_b = sample;
                L_mac_c = t0;
            end
            S_W_WR: begin
                writeEn   = 1'b1;
                writeAddr = scal_base + k;
                writeOut  = {{16{scaled[15]}}, scaled};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            mode       <= MODE_COPY;
            done       <= 1'b0;
            scale_mode <= 2'd0;
            t0         <= '0;
            ovf        <= 1'b0;
            k          <= '0;
`ifdef PITCH_OL_SCALE_ENERGY_EN
            energy     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        t0    <= '0;
                        ovf   <= 1'b0;
                        k     <= '0;
                        state <= S_E_RD;
                    end
                end
                S_E_RD: state <= S_E_ACC;
                S_E_ACC: begin
                    // t0 keeps taking the saturated result even after overflow has been flagged.
                    t0  <= L_mac_in;
                    ovf <= ovf | L_mac_overflow;
                    if (last) begin
                        k     <= '0;
                        state <= S_DECIDE;
                    end else begin
                        k     <= k + ADDR_W'(1);
                        state <= S_E_RD;
                    end
                end
                S_DECIDE: begin
                    mode  <= select_mode(ovf, t0, ENER_THRESH);
`ifdef PITCH_OL_SCALE_ENERGY_EN
                    energy <= t0;
`endif
                    state <= S_W_RD;
                end
                S_W_RD: state <= S_W_WR;
                S_W_WR: begin
                    if (last) begin
                        // Publish the mode together with done so it is valid from the pulse onward.
                        done       <= 1'b1;
                        scale_mode <= mode;
                        state      <= S_DONE;
                    end else begin
                        k     <= k + ADDR_W'(1);
                        state <= S_W_RD;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pitch_ol_scale.sv
// Directed and randomized bench for pitch_ol_scale with a memory model, an L_mac model and a sum-of-squares reference.
module tb_pitch_ol_scale;

    localparam int PM = 143;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [11:0] signal;
    logic [11:0] scal_sig;
    logic [15:0] L_frame;
    logic [11:0] readAddr;
    logic [31:0] readIn;
    logic [11:0] writeAddr;
    logic [31:0] writeOut;
    logic        writeEn;
    logic [15:0] L_mac_a;
    logic [15:0] L_mac_b;
    logic [31:0] L_mac_c;
    logic [31:0] L_mac_in;
    logic        L_mac_overflow;
    logic [1:0]  scale_mode;
`ifdef PITCH_OL_SCALE_ENERGY_EN
    logic [31:0] energy;
`endif

    always #5 clk = ~clk;

    pitch_ol_scale dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .done           (done),
        .signal         (signal),
        .scal_sig       (scal_sig),
        .L_frame        (L_frame),
        .readAddr       (readAddr),
        .readIn         (readIn),
        .writeAddr      (writeAddr),
        .writeOut       (writeOut),
        .writeEn        (writeEn),
        .L_mac_a        (L_mac_a),
        .L_mac_b        (L_mac_b),
        .L_mac_c        (L_mac_c),
        .L_mac_in       (L_mac_in),
        .L_mac_overflow (L_mac_overflow),
        .scale_mode     (scale_mode)
`ifdef PITCH_OL_SCALE_ENERGY_EN
        ,
        .energy         (energy)
`endif
    );

    // Shared memory: one-cycle read latency, upper half of the word is junk the DUT must ignore.
    logic [15:0] mem [0:4095];
    logic [11:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    always @(posedge clk) begin
        readIn <= {16'($urandom), mem[readAddr]};
        if (writeEn) begin
            mem[writeAddr] = writeOut[15:0];
            wr_addr_q.push_back(writeAddr);
            wr_data_q.push_back(writeOut);
        end
    end

    // G.729 L_mac: saturate(c + saturate(2*a*b)).
    longint lm_p, lm_s;
    logic   lm_o1, lm_o2;
    always_comb begin
        lm_p  = 64'sd2 * longint'($signed(L_mac_a)) * longint'($signed(L_mac_b));
        lm_o1 = 1'b0;
        if (lm_p > 64'sd2147483647) begin
            lm_p  = 64'sd2147483647;
            lm_o1 = 1'b1;
        end
        lm_s  = lm_p + longint'($signed(L_mac_c));
        lm_o2 = 1'b0;
        if (lm_s > 64'sd2147483647) begin
            lm_s  = 64'sd2147483647;
            lm_o2 = 1'b1;
        end else if (lm_s < -64'sd2147483648) begin
            lm_s  = -64'sd2147483648;
            lm_o2 = 1'b1;
        end
        L_mac_in       = lm_s[31:0];
        L_mac_overflow = lm_o1 | lm_o2;
    end

    int n_total = 0;
    int n_pass  = 0;
    int samp [0:4095];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int f_ref(input int x, input int m);
        int v;
        if (m == 1) begin
            v = x * 8;
            if (v > 32767)  v = 32767;
            if (v < -32768) v = -32768;
        end else if (m == 2) begin
            v = x >>> 3;
        end else begin
            v = x;
        end
        return v;
    endfunction

    task automatic load(input int n, input logic [11:0] sb);
        logic [11:0] a;
        for (int i = 0; i < n; i++) begin
            a = sb - 12'(PM) + 12'(i);
            mem[a] = 16'(samp[i]);
        end
    endtask

    // One complete operation: stimulus, bounded wait for done, then compare against the reference.
    task automatic run_op(input string tag, input int lf, input logic [11:0] sb,
                          input logic [11:0] cb, input int busy_at);
        int          n, cyc, bad, exp_mode;
        longint      tot;
        logic        exp_ovf;
        logic [11:0] ea;
        logic [31:0] ed;
        n = PM + lf;
        load(n, sb);
        signal   = sb;
        scal_sig = cb;
        L_frame  = 16'(lf);
        wr_addr_q.delete();
        wr_data_q.delete();

        tot = 0;
        for (int i = 0; i < n; i++) tot += 2 * longint'(samp[i]) * longint'(samp[i]);
        exp_ovf  = (tot > 64'sd2147483647);
        exp_mode = exp_ovf ? 2 : ((tot < 64'sd1048576) ? 1 : 0);

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        while (!done && cyc < 4 * n + 10) begin
            @(negedge clk);
            cyc++;
            start = (cyc == busy_at);
        end
        start = 1'b0;
        check({tag, ":latency"}, 64'(cyc), 64'(4 * n + 2));
        check({tag, ":mode_at_done"}, 64'(scale_mode), 64'(exp_mode));
`ifdef PITCH_OL_SCALE_ENERGY_EN
        check({tag, ":energy"}, 64'(energy), exp_ovf ? 64'h7FFF_FFFF : 64'(tot[31:0]));
`endif
        @(negedge clk);
        check({tag, ":done_width"}, 64'(done), 64'd0);
        check({tag, ":mode_held"}, 64'(scale_mode), 64'(exp_mode));
        check({tag, ":write_count"}, 64'(wr_addr_q.size()), 64'(n));
        bad = 0;
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            ea = cb - 12'(PM) + 12'(i);
            ed = 32'(f_ref(samp[i], exp_mode));
            if (wr_addr_q[i] !== ea || wr_data_q[i] !== ed) bad++;
        end
        check({tag, ":bad_writes"}, 64'(bad), 64'd0);
    endtask

    task automatic fill_const(input int n, input int v);
        for (int i = 0; i < n; i++) samp[i] = v;
    endtask

    task automatic fill_rand(input int n, input int cls);
        for (int i = 0; i < n; i++) begin
            if (cls == 0)      samp[i] = int'($urandom_range(0, 31)) - 16;
            else if (cls == 1) samp[i] = int'($urandom_range(0, 1200)) - 600;
            else               samp[i] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    initial begin
        int          cyc, snap, dones, wr_after, lf, cls;
        logic [11:0] sb, cb, target;

        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        reset = 1'b1; start = 1'b0;
        signal = 12'd300; scal_sig = 12'd1200; L_frame = 16'd80;
        repeat (3) @(negedge clk);
        check("reset:done", 64'(done), 64'd0);
        check("reset:scale_mode", 64'(scale_mode), 64'd0);
        check("reset:writeEn", 64'(writeEn), 64'd0);
        check("reset:readAddr", 64'(readAddr), 64'd0);
        check("reset:L_mac_c", 64'(L_mac_c), 64'd0);
`ifdef PITCH_OL_SCALE_ENERGY_EN
        check("reset:energy", 64'(energy), 64'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        fill_const(223, 0);   run_op("zeros", 80, 12'd300, 12'd1200, 0);
        fill_const(223, 10);  run_op("tens", 80, 12'd300, 12'd1200, 0);
        fill_const(223, 100); run_op("hundreds", 80, 12'd50, 12'd3000, 0);
        fill_const(223, 0); samp[7] = 512; samp[150] = 512;
        run_op("thr_512", 80, 12'd300, 12'd1200, 0);
        fill_const(223, 0); samp[7] = 511; samp[150] = 511;
        run_op("thr_511", 80, 12'd300, 12'd1200, 0);
        for (int i = 0; i < 223; i++) samp[i] = (i % 2 == 0) ? 32767 : -32768;
        run_op("alt_ovf", 80, 12'd4000, 12'd2000, 25);

        // Reset during the write of k=50: nothing may follow it.
        fill_const(223, 0);
        load(223, 12'd300);
        signal = 12'd300; scal_sig = 12'd1200; L_frame = 16'd80;
        wr_addr_q.delete(); wr_data_q.delete();
        target = 12'd1200 - 12'(PM) + 12'd50;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        while (!(writeEn && writeAddr == target) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid:reached_k50", 64'(writeEn && writeAddr == target), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        snap = wr_addr_q.size();
        check("rst_mid:writes_before", 64'(snap), 64'd51);
        check("rst_mid:scale_mode", 64'(scale_mode), 64'd0);
        dones = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        wr_after = wr_addr_q.size() - snap;
        check("rst_mid:writes_after", 64'(wr_after), 64'd0);
        check("rst_mid:dones", 64'(dones), 64'd0);
        fill_const(223, 10);
        run_op("after_rst", 80, 12'd300, 12'd1200, 40);

        for (int r = 0; r < 9; r++) begin
            lf  = int'($urandom_range(1, 60));
            cls = r % 3;
            fill_rand(PM + lf, cls);
            sb  = 12'($urandom_range(0, 4095));
            cb  = (r % 4 == 1) ? sb : sb + 12'd2048;
            run_op($sformatf("rand%0d", r), lf, sb, cb, (r % 2 == 0) ? 30 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pitch_ol_scale.md
Name: pitch_ol_scale

Overview:
- Upstream stage of the open-loop pitch search (G.729 Pitch_ol front end).
- Pass 1 computes the energy of signal[-PIT_MAX .. L_frame-1] with L_mac, tracking sticky overflow.
- Pass 2 writes a scaled copy, scal_sig, into working memory; the lag-maximisation stage then searches that copy.
- Shares the single-port memory and the external L_mac operator with its neighbours.

Parameters:
- PIT_MAX, 143, number of history samples before signal[0].
- ADDR_W, 12, memory address width.
- ENER_THRESH, 32'h0010_0000, energy threshold (2^20) below which the signal is up-scaled.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- start  in  1  begin operation; sampled only in IDLE.
- done  out  1  one-cycle completion pulse.
- signal  in  ADDR_W  address of signal[0].
- scal_sig  in  ADDR_W  address of scal_sig[0].
- L_frame  in  16  frame length; 0 < L_frame, PIT_MAX+L_frame <= 2^ADDR_W.
- readAddr  out  ADDR_W  memory read address.
- readIn  in  32  memory data; sample is readIn[15:0]; valid the cycle after readAddr.
- writeAddr  out  ADDR_W  memory write address.
- writeOut  out  32  write data, sign-extended 16-bit sample.
- writeEn  out  1  write strobe.
- L_mac_a  out  16  operand a to the shared L_mac.
- L_mac_b  out  16  operand b to the shared L_mac.
- L_mac_c  out  32  accumulator to the shared L_mac.
- L_mac_in  in  32  L_mac result (combinational).
- L_mac_overflow  in  1  L_mac saturation flag (combinational).
- scale_mode  out  2  0 = copy, 1 = shl 3, 2 = shr 3; valid from done until the next start.

Behaviour:
- Reset values: done=0, scale_mode=0, state IDLE, accumulator t0=0, overflow flag=0, index k=0.
- All memory and L_mac outputs are combinational and default to 0 outside their states.
- N = PIT_MAX + L_frame. Sample k (0..N-1) lives at signal - PIT_MAX + k, 12-bit wrap. It is written to scal_sig - PIT_MAX + k.
- IDLE: on start, clear t0, ovf and k, then go to E_RD. While not in IDLE, start is ignored.
- E_RD: readAddr = signal - PIT_MAX + k; go to E_ACC.
- E_ACC: L_mac_a = L_mac_b = readIn[15:0], L_mac_c = t0; t0 <= L_mac_in; ovf <= ovf | L_mac_overflow.
  - If k == N-1: k <= 0, go to DECIDE. Otherwise k++, go to E_RD.
- DECIDE: if ovf, mode = 2; else if signed t0 < ENER_THRESH, mode = 1; else mode = 0. The mode is held internally. Go to W_RD.
- W_RD: readAddr = signal - PIT_MAX + k; go to W_WR.
- W_WR: writeEn = 1, writeAddr = scal_sig - PIT_MAX + k, writeOut = sign-extended f(readIn[15:0]). f by mode:
  - mode 0: identity.
  - mode 1: shl 3 with 16-bit saturation to 0x7FFF / 0x8000.
  - mode 2: arithmetic shr 3.
  - If k == N-1, go to DONE. Otherwise k++, go to W_RD.
- DONE: done = 1 (registered, exactly one cycle); scale_mode <= mode; go to IDLE.
- Latency: done is high in cycle 4N+2, counting the start-sampling cycle as 0. Exactly N writes, in ascending address order.
- Once set, ovf stays set for the pass; t0 keeps accumulating saturated values.
- In-place operation (scal_sig == signal) is legal, because each read precedes its write.
- reset mid-operation returns to IDLE on the next edge with no further writes; scale_mode returns to 0.

Optional Feature:
- PITCH_OL_SCALE_ENERGY_EN defined: adds output port energy (32 bits), loaded with the final t0 in DECIDE and held until the next start. Reset value 0.
- Not defined: the port is absent and there is no extra register.

Decomposition:
- Shared package: state encoding (IDLE, E_RD, E_ACC, DECIDE, W_RD, W_WR, DONE), scale_mode codes, PIT_MAX, ENER_THRESH.
- One natural sub-module, pitch_ol_shift3: combinational mode-selected shl3-saturate / shr3 / pass-through on 16 bits, reusable by later stages.

Test Plan:
- All samples 0, L_frame=80 (N=223) -> mode 1, 223 writes of 0, done high in cycle 894.
- All samples 10 -> energy 44600 < 2^20 -> mode 1, every write 80.
- All samples 100 -> energy 4,460,000 -> mode 0, every write 100.
- Two samples of 512, rest 0 -> energy exactly 1,048,576 -> mode 0 (boundary, not shl). Repeat with 511 -> mode 1, writes 4088.
- Alternating 32767 / -32768 -> overflow on sample 2 -> mode 2, writes 4095 / -4096 (0xFFFF_F000).
- Assert reset during W_WR at k=50 -> no writes after that cycle, done never pulses, scale_mode=0. A new start then completes normally. Start pulses while busy are ignored.
